// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised write ports,
// post-reset clear sequencer. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
  output logic [NUM_RD*DATA_W-1:0]   rdData,
  input  logic                       wrEn0,
  input  logic [ADDR_W-1:0]          wrAddr0,
  input  logic [DATA_W-1:0]          wrData0,
  input  logic                       wrEn1,
  input  logic [ADDR_W-1:0]          wrAddr1,
  input  logic [DATA_W-1:0]          wrData1,
  output logic                       ready
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wr0_ok, wr1_ok;

  // In range and not the hardwired-zero entry.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wr0_ok = (state_q == StRun) && wrEn0 && addr_valid(wrAddr0);
    wr1_ok = (state_q == StRun) && wrEn1 && addr_valid(wrAddr1);
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    if (state_q == StClear) begin
      if (clr_ptr_q == LastPtr) begin
        state_d   = StRun;
        ready_d   = 1'b1;
        clr_ptr_d = '0;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (state_q == StClear) begin
        if (clr_ptr_q == ADDR_W'(i)) mem_d[i] = '0;
      end else begin
        if (wr0_ok && (wrAddr0 == ADDR_W'(i))) mem_d[i] = wrData0;
        if (wr1_ok && (wrAddr1 == ADDR_W'(i))) mem_d[i] = wrData1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rdAddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      if ((state_q == StRun) && addr_valid(addr)) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (addr == ADDR_W'(i)) data = mem_q[i];
        end
`ifdef RF_BYPASS_EN
        if (wr1_ok && (wrAddr1 == addr)) begin
          data = wrData1;
        end else if (wr0_ok && (wrAddr0 == addr)) begin
          data = wrData0;
        end
`endif
      end
    end

    assign rdData[k*DATA_W +: DATA_W] = data;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (default, ZERO_REG=0, DEPTH=20) share stimulus;
// expected read data goes through a scoreboard queue.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data, rd_data_nz, rd_data_sm;
  logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [4:0]  wr_addr0 = '0, wr_addr1 = '0;
  logic [31:0] wr_data0 = '0, wr_data1 = '0;
  logic        ready, ready_nz, ready_sm;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       tag;
    int          inst;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rdAddr(rd_addr), .rdData(rd_data),
    .wrEn0(wr_en0), .wrAddr0(wr_addr0), .wrData0(wr_data0),
    .wrEn1(wr_en1), .wrAddr1(wr_addr1), .wrData1(wr_data1), .ready(ready)
  );

  regfile_mp #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .rdAddr(rd_addr), .rdData(rd_data_nz),
    .wrEn0(wr_en0), .wrAddr0(wr_addr0), .wrData0(wr_data0),
    .wrEn1(wr_en1), .wrAddr1(wr_addr1), .wrData1(wr_data1), .ready(ready_nz)
  );

  regfile_mp #(.DEPTH(20), .ZERO_REG(1)) dut_sm (
    .clk(clk), .rst(rst), .rdAddr(rd_addr), .rdData(rd_data_sm),
    .wrEn0(wr_en0), .wrAddr0(wr_addr0), .wrData0(wr_data0),
    .wrEn1(wr_en1), .wrAddr1(wr_addr1), .wrData1(wr_data1), .ready(ready_sm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic push(input string tag, input int inst, input int port, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.inst = inst; e.port = port; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0:       obs = rd_data[e.port*32 +: 32];
        1:       obs = rd_data_nz[e.port*32 +: 32];
        default: obs = rd_data_sm[e.port*32 +: 32];
      endcase
      n_checks++;
      assert (obs === e.val) else begin
        n_fails++;
        $error("FAIL %s inst%0d port%0d: observed %h expected %h", e.tag, e.inst, e.port, obs,
               e.val);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      push(tag, 0, 0, 32'h0);
      push(tag, 0, 1, 32'h0);
      push(tag, 1, 0, 32'h0);
      check_sb();
    end
  endtask

  initial begin
    // 1. Reset and clear sequencing
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("reset_ready", ready, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (k % 8 == 1) begin
        set_rd(5'd5, 5'd0);
        push("clear_read", 0, 0, 32'h0);
        push("clear_read", 1, 1, 32'h0);
        check_sb();
      end
      tick();
      check_bit($sformatf("clear_ready_k%0d", k), ready, logic'(k == 32));
      if (k == 20 || k == 19) check_bit($sformatf("sm_ready_k%0d", k), ready_sm, logic'(k >= 20));
    end
    check_all_zero("after_clear");

    // 2. Basic write then dual read
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
    tick();
    wr_en0 = 1'b0;
    set_rd(5'd5, 5'd5);
    push("basic", 0, 0, 32'hDEADBEEF);
    push("basic", 0, 1, 32'hDEADBEEF);
    check_sb();

    // 3. Same-address collision, then distinct addresses
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22;
    tick();
    wr_addr0 = 5'd8; wr_addr1 = 5'd9;
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    set_rd(5'd7, 5'd8);
    push("collide7", 0, 0, 32'h22);
    push("dual8", 0, 1, 32'h11);
    check_sb();
    set_rd(5'd9, 5'd5);
    push("dual9", 0, 0, 32'h22);
    push("keep5", 0, 1, 32'hDEADBEEF);
    check_sb();

    // 4. Hardwired zero entry
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF;
    tick();
    wr_en0 = 1'b0;
    set_rd(5'd0, 5'd0);
    push("zero_reg", 0, 0, 32'h0);
    push("no_zero_reg", 1, 1, 32'hFFFF_FFFF);
    check_sb();

    // Out-of-range on the 20-entry instance
    wr_en0 = 1'b1; wr_addr0 = 5'd25; wr_data0 = 32'h77;
    wr_en1 = 1'b1; wr_addr1 = 5'd19; wr_data1 = 32'h19;
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    set_rd(5'd25, 5'd19);
    push("oor_read", 2, 0, 32'h0);
    push("last_entry", 2, 1, 32'h19);
    push("in_range25", 0, 0, 32'h77);
    check_sb();

    // 5. Same-cycle write/read
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hA;
    tick();
    wr_data0 = 32'hB;
    wr_en1 = 1'b1; wr_addr1 = 5'd0; wr_data1 = 32'h5A5A;
    set_rd(5'd3, 5'd0);
`ifdef RF_BYPASS_EN
    push("bypass3", 0, 0, 32'hB);
    push("bypass0_nz", 1, 1, 32'h5A5A);
`else
    push("bypass3", 0, 0, 32'hA);
    push("bypass0_nz", 1, 1, 32'hFFFF_FFFF);
`endif
    push("bypass0_zero", 0, 1, 32'h0);
    check_sb();
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    push("after3", 0, 0, 32'hB);
    push("after0_nz", 1, 1, 32'h5A5A);
    check_sb();

    wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h40;
    wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 32'h41;
    set_rd(5'd4, 5'd4);
`ifdef RF_BYPASS_EN
    push("bypass_prio", 0, 1, 32'h41);
`else
    push("bypass_prio", 0, 1, 32'h0);
`endif
    check_sb();
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    push("after_prio", 0, 0, 32'h41);
    check_sb();

    // 6. Reset mid-clear with writes attempted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h55;
    wr_en1 = 1'b1; wr_addr1 = 5'd6; wr_data1 = 32'h66;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_bit($sformatf("mid_ready_k%0d", k), ready, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k % 8 == 2) begin
        set_rd(5'd3, 5'd5);
        push("reclear_read", 0, 0, 32'h0);
        push("reclear_read", 0, 1, 32'h0);
        check_sb();
      end
      tick();
      if (k >= 30) check_bit($sformatf("reclear_ready_k%0d", k), ready, logic'(k == 32));
    end
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    check_all_zero("after_reclear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
